// File: rtl/ghr_checkpoint_ctrl.sv
// Speculative global-history register with an in-order checkpoint FIFO.
// Predictions shift into the GHR at DEC; EX resolution retires or restores from the oldest checkpoint.
module ghr_checkpoint_ctrl #(
   parameter int BPRED_WIDTH = 32,
   parameter int DEPTH       = 4,
   parameter int PTR_W       = 2
) (
   input  logic                   i_Clk,
   input  logic                   i_Reset,
   input  logic                   i_DEC_Is_Branch,
   input  logic                   i_Prediction,
   input  logic                   i_ALU_Branch_Valid,
   input  logic                   i_ALU_Branch_Outcome,
   output logic [BPRED_WIDTH-1:0] o_Global_History,
   output logic                   o_Stall_Full,
   output logic                   o_Mispredict,
   output logic [PTR_W:0]         o_Count,
   output logic                   o_Error
);

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = (PTR_W)'(1);

   logic [BPRED_WIDTH-1:0] ghr_q, ghr_d;
   logic [PTR_W:0]         count_q, count_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic                   mis_q, mis_d;
   logic                   err_q, err_d;

   logic [BPRED_WIDTH-1:0] hist_q [DEPTH];
   logic [DEPTH-1:0]       pred_q;

   logic                   full;
   logic                   empty;
   logic [BPRED_WIDTH-1:0] rd_hist;
   logic                   rd_pred;
   logic                   pop_ok;
   logic                   mis;
   logic                   push;

   always_comb begin
      full    = (count_q == CNT_FULL);
      empty   = (count_q == '0);
      rd_hist = hist_q[rd_ptr_q];
      rd_pred = pred_q[rd_ptr_q];
      pop_ok  = i_ALU_Branch_Valid & ~empty & (i_ALU_Branch_Outcome == rd_pred);
      mis     = i_ALU_Branch_Valid & ~empty & (i_ALU_Branch_Outcome != rd_pred);
      // A branch in DEC during a mispredict is on the wrong path and never checkpointed.
      push    = i_DEC_Is_Branch & (~full | pop_ok) & ~mis;
   end

   always_comb begin
      ghr_d    = ghr_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      mis_d    = mis;
      err_d    = err_q;

      if (mis) begin
         ghr_d    = {rd_hist[BPRED_WIDTH-2:0], i_ALU_Branch_Outcome};
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push) begin
            ghr_d    = {ghr_q[BPRED_WIDTH-2:0], i_Prediction};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         unique case ({push, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end

      // Protocol violations latch until reset; the offending operation has no other effect.
      if (i_ALU_Branch_Valid & empty) begin
         err_d = 1'b1;
      end
      if (i_DEC_Is_Branch & full & ~pop_ok & ~mis) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         ghr_q    <= '0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         mis_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         ghr_q    <= ghr_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         mis_q    <= mis_d;
         err_q    <= err_d;
      end
   end

   // Checkpoint payload is only meaningful while counted, so it carries no reset.
   always_ff @(posedge i_Clk) begin
      if (push) begin
         hist_q[wr_ptr_q] <= ghr_q;
         pred_q[wr_ptr_q] <= i_Prediction;
      end
   end

   assign o_Global_History = ghr_q;
   assign o_Stall_Full     = full;
   assign o_Mispredict     = mis_q;
   assign o_Count          = count_q;
   assign o_Error          = err_q;

endmodule

// File: tb/tb_ghr_checkpoint_ctrl.sv
// Vector table plus scoreboard bench for ghr_checkpoint_ctrl (BPRED_WIDTH=8, DEPTH=4).
module tb_ghr_checkpoint_ctrl;

   logic       clk;
   logic       rst_n;
   logic       dec, pred, alu_v, alu_o;
   logic [7:0] ghr;
   logic       stall_full, mispredict, err;
   logic [2:0] cnt;

   ghr_checkpoint_ctrl #(.BPRED_WIDTH(8), .DEPTH(4), .PTR_W(2)) dut (
      .i_Clk               (clk),
      .i_Reset             (rst_n),
      .i_DEC_Is_Branch     (dec),
      .i_Prediction        (pred),
      .i_ALU_Branch_Valid  (alu_v),
      .i_ALU_Branch_Outcome(alu_o),
      .o_Global_History    (ghr),
      .o_Stall_Full        (stall_full),
      .o_Mispredict        (mispredict),
      .o_Count             (cnt),
      .o_Error             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       do_rst;
      logic       dec;
      logic       pred;
      logic       alu_v;
      logic       alu_o;
      logic [7:0] e_ghr;
      logic [2:0] e_cnt;
      logic       e_full;
      logic       e_mis;
      logic       e_err;
   } vec_t;

   vec_t        tbl[$];
   logic [13:0] sb[$];
   int          n_cmp  = 0;
   int          n_fail = 0;

   task automatic add(input string nm, input logic r, input logic d, input logic p,
                      input logic v, input logic o, input logic [7:0] g, input logic [2:0] c,
                      input logic f, input logic m, input logic e);
      vec_t t;
      t.name = nm; t.do_rst = r; t.dec = d; t.pred = p; t.alu_v = v; t.alu_o = o;
      t.e_ghr = g; t.e_cnt = c; t.e_full = f; t.e_mis = m; t.e_err = e;
      tbl.push_back(t);
   endtask

   function automatic logic [13:0] pack(input logic [7:0] g, input logic [2:0] c,
                                        input logic f, input logic m, input logic e);
      return {g, c, f, m, e};
   endfunction

   task automatic compare(input string nm, input logic [13:0] want);
      logic [13:0] got;
      got = pack(ghr, cnt, stall_full, mispredict, err);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got ghr=%h cnt=%0d full=%b mis=%b err=%b, want ghr=%h cnt=%0d full=%b mis=%b err=%b",
                  nm, got[13:6], got[5:3], got[2], got[1], got[0],
                  want[13:6], want[5:3], want[2], want[1], want[0]);
      end
   endtask

   task automatic check_sb(input string nm);
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got ghr=%h want an entry", nm, ghr);
      end else begin
         compare(nm, sb.pop_front());
      end
   endtask

   task automatic drive(input logic d, input logic p, input logic v, input logic o,
                        input logic [13:0] want, input string nm);
      dec = d; pred = p; alu_v = v; alu_o = o;
      sb.push_back(want);
      @(posedge clk);
      #1;
      dec = 1'b0; pred = 1'b0; alu_v = 1'b0; alu_o = 1'b0;
      check_sb(nm);
   endtask

   task automatic do_reset();
      dec = 1'b0; pred = 1'b0; alu_v = 1'b0; alu_o = 1'b0;
      rst_n = 1'b0;
      #1;
      compare("reset_held", pack(8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] m_ghr;
      logic       p;

      rst_n = 1'b1;
      dec = 1'b0; pred = 1'b0; alu_v = 1'b0; alu_o = 1'b0;

      //  name            rst dec prd  v   o   ghr    cnt full mis err
      add("reset_idle",   1, 0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0);
      add("push1",        0, 1, 1, 0, 0, 8'h01, 3'd1, 0, 0, 0);
      add("push2",        0, 1, 1, 0, 0, 8'h03, 3'd2, 0, 0, 0);
      add("push3",        0, 1, 1, 0, 0, 8'h07, 3'd3, 0, 0, 0);
      add("resolve_ok",   0, 0, 0, 1, 1, 8'h07, 3'd2, 0, 0, 0);
      add("resolve_mis",  0, 1, 1, 1, 0, 8'h02, 3'd0, 0, 1, 0);
      add("mis_deassert", 0, 0, 0, 0, 0, 8'h02, 3'd0, 0, 0, 0);
      add("fill1",        0, 1, 0, 0, 0, 8'h04, 3'd1, 0, 0, 0);
      add("fill2",        0, 1, 0, 0, 0, 8'h08, 3'd2, 0, 0, 0);
      add("fill3",        0, 1, 0, 0, 0, 8'h10, 3'd3, 0, 0, 0);
      add("fill4",        0, 1, 0, 0, 0, 8'h20, 3'd4, 1, 0, 0);
      add("push_full",    0, 1, 0, 0, 0, 8'h20, 3'd4, 1, 0, 1);
      add("push_pop_full",0, 1, 1, 1, 0, 8'h41, 3'd4, 1, 0, 1);
      add("mis_when_full",0, 0, 0, 1, 1, 8'h09, 3'd0, 0, 1, 1);
      add("idle_sticky",  0, 0, 0, 0, 0, 8'h09, 3'd0, 0, 0, 1);
      add("empty_resolve",1, 0, 0, 1, 1, 8'h00, 3'd0, 0, 0, 1);

      foreach (tbl[i]) begin
         if (tbl[i].do_rst) do_reset();
         drive(tbl[i].dec, tbl[i].pred, tbl[i].alu_v, tbl[i].alu_o,
               pack(tbl[i].e_ghr, tbl[i].e_cnt, tbl[i].e_full, tbl[i].e_mis, tbl[i].e_err),
               tbl[i].name);
      end

      // Six push/correct-resolve pairs walk both pointers past the wrap point.
      do_reset();
      m_ghr = 8'h00;
      for (int k = 0; k < 6; k++) begin
         p = 1'(k % 2);
         m_ghr = {m_ghr[6:0], p};
         drive(1'b1, p, 1'b0, 1'b0, pack(m_ghr, 3'd1, 1'b0, 1'b0, 1'b0), "wrap_push");
         drive(1'b0, 1'b0, 1'b1, p, pack(m_ghr, 3'd0, 1'b0, 1'b0, 1'b0), "wrap_resolve");
      end

      // Asynchronous reset asserted between edges with history in flight.
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 1'b0, pack(8'h01, 3'd1, 1'b0, 1'b0, 1'b0), "mid_push1");
      drive(1'b1, 1'b1, 1'b0, 1'b0, pack(8'h03, 3'd2, 1'b0, 1'b0, 1'b0), "mid_push2");
      drive(1'b1, 1'b1, 1'b0, 1'b0, pack(8'h07, 3'd3, 1'b0, 1'b0, 1'b0), "mid_push3");
      rst_n = 1'b0;
      #2;
      compare("async_reset", pack(8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
      #1;
      rst_n = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, pack(8'h01, 3'd1, 1'b0, 1'b0, 1'b0), "post_reset_push");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
